// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Non-memory ops retire one cycle after acceptance. Loads and stores run a
// req/ack transaction on the data-memory port. While that transaction is open,
// in_ready is low and upstream is stalled.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN. When it is defined, a
// memory op whose address has F_in[1:0] != 2'b00 is trapped with mem_fault
// and issues no request. When it is undefined, the low two address bits are
// forced to zero.
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       F_in,
   input  logic [31:0]       B_in,
   input  logic [4:0]        DA_in,
   input  logic              RW_in,
   input  logic [1:0]        MD_in,
   input  logic              MW_in,
   input  logic              N_xor_V_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       F_out,
   output logic [31:0]       memData,
   output logic [4:0]        DA,
   output logic              RW,
   output logic [1:0]        MD,
   output logic              N_xor_V,
   output logic              out_valid,
   output logic              mem_fault
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   // Counter value at which an unacknowledged access is abandoned.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   logic [0:0]        state_r;
   logic [7:0]        count_r;

   // Op fields captured at acceptance and replayed on retirement.
   logic [31:0]       f_lat_r;
   logic [4:0]        da_lat_r;
   logic              rw_lat_r;
   logic [1:0]        md_lat_r;
   logic              nxv_lat_r;

   logic              accept_s;
   logic              is_mem_s;
   logic              misalign_s;
   logic              timeout_s;
   logic [ADDR_W-1:0] addr_s;

   // Handshake decode, address formation and timeout detection.
   always_comb begin
      in_ready  = (state_r == IDLE);
      accept_s  = in_valid & (state_r == IDLE);
      is_mem_s  = accept_s & ((MD_in == 2'b01) | MW_in);
      timeout_s = (count_r == LAST_CNT);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_s = (F_in[1:0] != 2'b00);
      addr_s     = F_in[ADDR_W-1:0];
`else
      misalign_s = 1'b0;
      addr_s     = {F_in[ADDR_W-1:2], 2'b00};
`endif
   end

   // Stage state machine, memory port drive and writeback output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         count_r   <= 8'd0;
         f_lat_r   <= 32'd0;
         da_lat_r  <= 5'd0;
         rw_lat_r  <= 1'b0;
         md_lat_r  <= 2'b00;
         nxv_lat_r <= 1'b0;
         F_out     <= 32'd0;
         memData   <= 32'd0;
         DA        <= 5'd0;
         RW        <= 1'b0;
         MD        <= 2'b00;
         N_xor_V   <= 1'b0;
         out_valid <= 1'b0;
         mem_fault <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 32'd0;
      end else begin
         // Pulses drop by default. RW is only high alongside out_valid.
         out_valid <= 1'b0;
         mem_fault <= 1'b0;
         RW        <= 1'b0;
         case (state_r)
            IDLE: begin
               if (is_mem_s) begin
                  if (misalign_s) begin
                     out_valid <= 1'b1;
                     mem_fault <= 1'b1;
                  end else begin
                     f_lat_r   <= F_in;
                     da_lat_r  <= DA_in;
                     rw_lat_r  <= RW_in;
                     md_lat_r  <= MD_in;
                     nxv_lat_r <= N_xor_V_in;
                     mem_addr  <= addr_s;
                     mem_wdata <= B_in;
                     mem_we    <= MW_in;
                     mem_req   <= 1'b1;
                     count_r   <= 8'd0;
                     state_r   <= ACCESS;
                  end
               end else if (accept_s) begin
                  F_out     <= F_in;
                  DA        <= DA_in;
                  RW        <= RW_in;
                  MD        <= MD_in;
                  N_xor_V   <= N_xor_V_in;
                  memData   <= 32'd0;
                  out_valid <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               if (mem_ack) begin
                  // Read data is returned only when the op selects memory in writeback.
                  memData   <= (md_lat_r == 2'b01) ? mem_rdata : 32'd0;
                  F_out     <= f_lat_r;
                  DA        <= da_lat_r;
                  RW        <= rw_lat_r;
                  MD        <= md_lat_r;
                  N_xor_V   <= nxv_lat_r;
                  out_valid <= 1'b1;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  state_r   <= IDLE;
               end else if (timeout_s) begin
                  memData   <= 32'd0;
                  out_valid <= 1'b1;
                  mem_fault <= 1'b1;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  count_r <= count_r + 8'd1;
               end
            end
            default: begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage using a retirement scoreboard.
// Expected retirements are queued when their op is driven. They are popped
// and compared when out_valid is seen.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] F_in, B_in;
   logic [4:0]  DA_in;
   logic        RW_in;
   logic [1:0]  MD_in;
   logic        MW_in;
   logic        N_xor_V_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] F_out, memData;
   logic [4:0]  DA;
   logic        RW;
   logic [1:0]  MD;
   logic        N_xor_V, out_valid, mem_fault;

   typedef struct {
      logic [31:0] f;
      logic [31:0] mdata;
      logic [4:0]  da;
      logic        rw;
      logic [1:0]  md;
      logic        nxv;
      logic        fault;
   } ret_t;

   ret_t exp_q[$];
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   mem_stage #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .F_in(F_in), .B_in(B_in), .DA_in(DA_in), .RW_in(RW_in), .MD_in(MD_in),
      .MW_in(MW_in), .N_xor_V_in(N_xor_V_in), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .F_out(F_out), .memData(memData), .DA(DA), .RW(RW),
      .MD(MD), .N_xor_V(N_xor_V), .out_valid(out_valid), .mem_fault(mem_fault)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] f, input logic [31:0] mdata, input logic [4:0] da,
                       input logic rw, input logic [1:0] md, input logic nxv, input logic fault);
      ret_t r;
      r.f = f; r.mdata = mdata; r.da = da; r.rw = rw; r.md = md; r.nxv = nxv; r.fault = fault;
      exp_q.push_back(r);
   endtask

   task automatic drive(input logic [31:0] f, input logic [31:0] b, input logic [4:0] da,
                        input logic rw, input logic [1:0] md, input logic mw, input logic nxv);
      in_valid = 1'b1; F_in = f; B_in = b; DA_in = da; RW_in = rw;
      MD_in = md; MW_in = mw; N_xor_V_in = nxv;
   endtask

   // Scoreboard monitor: compare every retirement and check bubbles carry RW=0.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               ret_t e;
               e = exp_q.pop_front();
               chk("ret_fault", {31'd0, mem_fault}, {31'd0, e.fault});
               chk("ret_RW", {31'd0, RW}, {31'd0, e.rw});
               if (!e.fault) begin
                  chk("ret_F_out", F_out, e.f);
                  chk("ret_memData", memData, e.mdata);
                  chk("ret_DA", {27'd0, DA}, {27'd0, e.da});
                  chk("ret_MD", {30'd0, MD}, {30'd0, e.md});
                  chk("ret_N_xor_V", {31'd0, N_xor_V}, {31'd0, e.nxv});
               end
            end
         end else begin
            chk("bubble_RW", {31'd0, RW}, 32'd0);
            chk("bubble_fault", {31'd0, mem_fault}, 32'd0);
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      int n;
      reset = 1'b1; in_valid = 1'b0; F_in = 32'd0; B_in = 32'd0; DA_in = 5'd0;
      RW_in = 1'b0; MD_in = 2'b00; MW_in = 1'b0; N_xor_V_in = 1'b0;
      mem_ack = 1'b0; mem_rdata = 32'd0;
      tick(); tick();
      chk("rst_F_out", F_out, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      reset = 1'b0;
      tick();

      // Back-to-back non-memory ops: ADD then SLT.
      drive(32'h0000_0007, 32'd0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
      push(32'h0000_0007, 32'd0, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0);
      chk("add_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("add_out_valid", {31'd0, out_valid}, 32'd1);
      drive(32'h0000_0001, 32'd0, 5'd4, 1'b1, 2'b10, 1'b0, 1'b1);
      push(32'h0000_0001, 32'd0, 5'd4, 1'b1, 2'b10, 1'b1, 1'b0);
      chk("slt_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("slt_out_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      tick();

      // Load, acknowledged on the third ACCESS cycle.
      drive(32'h0000_0100, 32'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0);
      push(32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("ld_mem_req", {31'd0, mem_req}, 32'd1);
         chk("ld_in_ready", {31'd0, in_ready}, 32'd0);
         chk("ld_mem_addr", mem_addr, 32'h0000_0100);
         chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
         if (i == 2) begin
            mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
         end
         tick();
      end
      mem_ack = 1'b0;
      chk("ld_out_valid", {31'd0, out_valid}, 32'd1);
      chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
      chk("ld_in_ready_back", {31'd0, in_ready}, 32'd1);

      // Store with immediate acknowledge. Returned data must not reach memData.
      drive(32'h0000_0204, 32'h1234_5678, 5'd6, 1'b0, 2'b00, 1'b1, 1'b0);
      push(32'h0000_0204, 32'd0, 5'd6, 1'b0, 2'b00, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("st_mem_req", {31'd0, mem_req}, 32'd1);
      chk("st_mem_we", {31'd0, mem_we}, 32'd1);
      chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("st_mem_addr", mem_addr, 32'h0000_0204);
      chk("st_not_yet_valid", {31'd0, out_valid}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
      tick();
      mem_ack = 1'b0;
      chk("st_out_valid", {31'd0, out_valid}, 32'd1);
      chk("st_we_drop", {31'd0, mem_we}, 32'd0);

      // Timeout: with TIMEOUT_CYCLES=4, mem_req stays high for exactly 4 cycles.
      drive(32'h0000_0300, 32'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0);
      push(32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (mem_req === 1'b1) n++;
         tick();
      end
      chk("to_req_cycles", n, 32'd4);
      chk("to_in_ready", {31'd0, in_ready}, 32'd1);
      drive(32'h0000_0055, 32'd0, 5'd10, 1'b1, 2'b11, 1'b0, 1'b0);
      push(32'h0000_0055, 32'd0, 5'd10, 1'b1, 2'b11, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("to_next_op_valid", {31'd0, out_valid}, 32'd1);
      tick();

      // Reset on the second ACCESS cycle abandons the load.
      drive(32'h0000_0400, 32'd0, 5'd8, 1'b1, 2'b01, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("rma_req_before", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      chk("rma_F_out", F_out, 32'd0);
      chk("rma_memData", memData, 32'd0);
      chk("rma_DA", {27'd0, DA}, 32'd0);
      chk("rma_RW", {31'd0, RW}, 32'd0);
      chk("rma_MD", {30'd0, MD}, 32'd0);
      chk("rma_N_xor_V", {31'd0, N_xor_V}, 32'd0);
      chk("rma_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rma_fault", {31'd0, mem_fault}, 32'd0);
      chk("rma_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rma_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rma_mem_addr", mem_addr, 32'd0);
      chk("rma_mem_wdata", mem_wdata, 32'd0);
      chk("rma_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      mem_ack = 1'b0;
      chk("late_ack_ignored", {31'd0, out_valid}, 32'd0);
      chk("late_ack_no_req", {31'd0, mem_req}, 32'd0);
      tick();

      // Misaligned load at 0x102.
      drive(32'h0000_0102, 32'd0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      push(32'd0, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
      chk("mis_no_req", {31'd0, mem_req}, 32'd0);
      chk("mis_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("mis_no_req_later", {31'd0, mem_req}, 32'd0);
`else
      push(32'h0000_0102, 32'h1111_2222, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("mis_aligned_addr", mem_addr, 32'h0000_0100);
      chk("mis_req", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      mem_ack = 1'b0;
      chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
`endif
      tick(); tick(); tick();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the writeback stage.
- Accepts one execute result per handshake. Non-memory ops pass through with 1-cycle latency.
- Loads and stores run a request/acknowledge transaction on the data-memory port and stall upstream until the transaction completes.
- Presents F_out, memData, DA, RW, MD and N_xor_V to writeback, with a separate valid pulse.

Parameters:
- TIMEOUT_CYCLES, 15: max ACCESS cycles without mem_ack before abort; 1..255.
- ADDR_W, 32: data-memory address width; mem_addr = F_in[ADDR_W-1:0].

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  execute result present.
- in_ready  output  1  stage can accept; combinational, equals (state==IDLE).
- F_in  input  32  ALU result; also the memory address.
- B_in  input  32  store data.
- DA_in  input  5  destination register.
- RW_in  input  1  register write request.
- MD_in  input  2  writeback mux select: 00 ALU, 01 memory, 10 N_xor_V, 11 passed unchanged.
- MW_in  input  1  memory write.
- N_xor_V_in  input  1  set-less-than flag.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  32  store data.
- mem_ack  input  1  memory completion, 1-cycle pulse.
- mem_rdata  input  32  read data; valid with mem_ack.
- F_out  output  32  to writeback.
- memData  output  32  to writeback.
- DA  output  5  to writeback.
- RW  output  1  to writeback; 0 for every bubble.
- MD  output  2  to writeback.
- N_xor_V  output  1  to writeback.
- out_valid  output  1  one-cycle pulse per retired op.
- mem_fault  output  1  one-cycle pulse on timeout abort (or misalign, see below).

Behaviour:
- Reset:
  - state=IDLE, counter=0.
  - All registered outputs 0: F_out, memData, DA, RW, MD, N_xor_V, out_valid, mem_fault, mem_req, mem_we, mem_addr, mem_wdata.
  - Reset during ACCESS abandons the transaction: mem_req is low on the cycle after the reset edge, and no out_valid is produced.
- A memory op is in_valid & (MD_in==01 | MW_in). All other accepted inputs are non-memory ops.
- IDLE, non-memory op accepted:
  - Next edge: F_out, DA, MD, N_xor_V <= inputs; RW <= RW_in; memData <= 0; out_valid <= 1.
  - State stays IDLE; back-to-back ops retire at 1 per cycle.
- IDLE, memory op accepted:
  - Latch DA_in, RW_in, MD_in, N_xor_V_in and F_in.
  - Drive mem_addr <= F_in, mem_wdata <= B_in, mem_we <= MW_in, mem_req <= 1.
  - Counter <= 0; go to ACCESS.
  - Outputs that cycle: out_valid=0, RW=0.
- ACCESS:
  - in_ready=0.
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Counter increments each cycle without mem_ack.
- ACCESS with mem_ack:
  - Next edge: memData <= mem_rdata (0 for stores); F_out/DA/RW/MD/N_xor_V <= latched values.
  - out_valid <= 1; mem_req <= 0; mem_we <= 0; go to IDLE.
  - Minimum load/store latency is 2 cycles (ack on first ACCESS cycle).
- ACCESS, counter reaches TIMEOUT_CYCLES-1 with no ack:
  - Next edge: out_valid <= 1, RW <= 0, mem_fault <= 1, memData <= 0; mem_req <= 0; go to IDLE.
- mem_ack in IDLE is ignored.
- When out_valid=0, RW is 0; other outputs hold their last values.
- MW_in=1 with MD_in=01: performs a write; memData <= mem_rdata as returned.
- in_valid is ignored while in ACCESS. Upstream holds its inputs while in_ready=0.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - A memory op with F_in[1:0]!=00 issues no request.
  - Next edge: out_valid <= 1, RW <= 0, mem_fault <= 1; state stays IDLE.
- Undefined:
  - mem_addr = {F_in[ADDR_W-1:2], 2'b00}.
  - No misalign fault; mem_fault signals timeout only.

Test Plan:
- Non-memory ops: ADD F_in=0x0000_0007, DA=3, RW=1, MD=00, followed immediately by SLT MD=10, N_xor_V=1, DA=4 → out_valid on 2 consecutive cycles; F_out=7/DA=3/RW=1, then MD=10/N_xor_V=1/DA=4; in_ready constantly 1.
- Load: F_in=0x100, MD=01, DA=5, RW=1; ack after 3 ACCESS cycles with rdata=0xDEAD_BEEF → mem_req high 3 cycles, addr 0x100; then memData=0xDEADBEEF, RW=1, DA=5, out_valid=1; in_ready low 3 cycles.
- Store: F_in=0x204, B_in=0x1234_5678, MW=1, RW=0; immediate ack → mem_we=1, mem_wdata=0x12345678; out_valid 2 cycles after accept, RW=0, memData=0.
- Timeout: TIMEOUT_CYCLES=4, load with no ack → mem_req exactly 4 cycles; then out_valid=1, RW=0, mem_fault=1 for one cycle; next op accepted.
- Reset mid-ACCESS: assert reset on the 2nd ACCESS cycle → all outputs 0 the next cycle; late mem_ack ignored; in_ready=1.
- With MEM_STAGE_MISALIGN_TRAP_EN defined: load at F_in=0x102 → mem_req never asserts; mem_fault=1, RW=0, out_valid=1 one cycle later.
